uart_rx: RTL and testbench

- Serial receiver for the UART link.
- Consumes the 16x-oversampling tick from the baud generator and recovers frames from the `rx` pin: start bit, DATA_BITS data bits sent LSB first, optional parity, one stop bit.
- Presents each received word on a valid/ready interface, with framing, parity and overrun status, to the RISC-V peripheral register block.

---
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, majority-voted bit recovery with optional parity,
// delivering words on a valid/ready interface with framing, parity and overrun status.
module uart_rx #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_16x,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [3:0]           tcnt_q, tcnt_d;
  logic                 armed_q, armed_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 s7_q, s8_q, s9_q;
  logic                 s9_eff, vote, done;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d, pe_q, pe_d;
  logic                 ovr_q, ovr_d;
  logic                 fe_new, pe_new, handshake;

  // In STOP the frame completes on the tcnt=9 tick, so the third sample is taken live.
  assign s9_eff = (tcnt_q == 4'd9) ? rx_s_q : s9_q;
  assign vote   = (s7_q & s8_q) | (s7_q & s9_eff) | (s8_q & s9_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      tcnt_q    <= 4'd0;
      armed_q   <= 1'b0;
      idx_q     <= 3'd0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      s7_q      <= 1'b0;
      s8_q      <= 1'b0;
      s9_q      <= 1'b0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      armed_q   <= armed_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      if (tick_16x && tcnt_q == 4'd7) s7_q <= rx_s_q;
      if (tick_16x && tcnt_q == 4'd8) s8_q <= rx_s_q;
      if (tick_16x && tcnt_q == 4'd9) s9_q <= rx_s_q;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    armed_d = armed_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done    = 1'b0;
    if (tick_16x) begin
      tcnt_d = tcnt_q + 4'd1;
      case (state_q)
        StIdle: begin
          tcnt_d = 4'd0;
          if (armed_q && !rx_s_q) begin
            armed_d = 1'b0;
            state_d = StStart;
          end else if (rx_s_q) begin
            armed_d = 1'b1;
          end
        end
        StStart: begin
          if (tcnt_q == 4'd15) begin
            if (vote) begin
              state_d = StIdle;
            end else begin
              state_d = StData;
              idx_d   = 3'd0;
            end
          end
        end
        StData: begin
          if (tcnt_q == 4'd15) begin
            shift_d = {vote, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'(DATA_BITS - 1)) state_d = parity_en ? StParity : StStop;
          end
        end
        StParity: begin
          if (tcnt_q == 4'd15) begin
            par_d   = vote;
            state_d = StStop;
          end
        end
        StStop: begin
          if (tcnt_q == 4'd9) begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign fe_new    = ~vote;
  assign pe_new    = parity_en & (par_q ^ (^shift_q) ^ parity_odd);
  assign handshake = valid_q & rx_ready;

  always_comb begin
    rx_data_d = rx_data_q;
    valid_d   = valid_q;
    fe_d      = fe_q;
    pe_d      = pe_q;
    ovr_d     = ovr_q;
    if (done) begin
      if (!valid_q || rx_ready) begin
        rx_data_d = shift_q;
        fe_d      = fe_new;
        pe_d      = pe_new;
        valid_d   = 1'b1;
        if (handshake) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit, expected words go
// into a scoreboard queue and a monitor checks each accepted word.
module tb_uart_rx;

  localparam int unsigned DATA_BITS = 8;
  localparam int CLK_PER_BIT = 64;  // tick every 4 clk, 16 ticks per bit

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_16x = 1'b0;
  logic rx = 1'b1;
  logic parity_en = 1'b0;
  logic parity_odd = 1'b0;
  logic rx_ready = 1'b0;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid, frame_err, parity_err, overrun, busy;

  int total = 0;
  int bad = 0;
  int vcycles = 0;
  bit rdy_rand = 1'b0;
  bit rdy_fixed = 1'b1;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;
  exp_t q[$];

  uart_rx #(.DATA_BITS(DATA_BITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_16x   (tick_16x),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    int tdiv;
    tdiv = 0;
    forever begin
      @(posedge clk);
      #1;
      tdiv = (tdiv + 1) % 4;
      tick_16x = (tdiv == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rx_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rx_valid) begin
        vcycles++;
        if (rx_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got data %0h want no word", rx_data);
          end else begin
            e = q.pop_front();
            check("word_data", {24'd0, rx_data}, {24'd0, e.d});
            check("word_frame_err", {31'd0, frame_err}, {31'd0, e.fe});
            check("word_parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CLK_PER_BIT) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CLK_PER_BIT) @(posedge clk);
    #1;
  endtask

  // Reference: the word comes back as sent; frame_err when the stop bit is low; parity_err
  // when parity is on and the bit on the wire differs from the one that makes the count right.
  task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd,
                            input bit pflip, input bit stop, input bit push);
    int   ones;
    logic pbit_ok, pbit;
    exp_t e;
    parity_en  = pen;
    parity_odd = podd;
    ones    = $countones(d);
    pbit_ok = podd ? (ones % 2 == 0) : (ones % 2 == 1);
    pbit    = pbit_ok ^ pflip;
    e.d  = d;
    e.fe = !stop;
    e.pe = pen && (pbit != pbit_ok);
    if (push) q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
    rx = 1'b1;
  endtask

  initial begin
    int   v0;
    exp_t e;
    logic [7:0] d;
    bit pen, podd, pflip, stop;

    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // Basic frame
    v0 = vcycles;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_bits(1);
    check("basic_valid_cycles", 32'(vcycles - v0), 32'd1);
    check("basic_busy_idle", {31'd0, busy}, 32'd0);
    check("basic_drained", 32'(q.size()), 32'd0);

    // False start: line low for 4 ticks only
    v0 = vcycles;
    rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("false_start_busy", {31'd0, busy}, 32'd1);
    idle_bits(2);
    check("false_start_idle", {31'd0, busy}, 32'd0);
    check("false_start_no_word", 32'(vcycles - v0), 32'd0);

    // Parity error: 0x37 even parity, wrong parity bit
    send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    parity_en = 1'b0;

    // Break: line low for 3 frame times
    v0 = vcycles;
    e.d = 8'h00;
    e.fe = 1'b1;
    e.pe = 1'b0;
    q.push_back(e);
    rx = 1'b0;
    repeat (3 * 10 * CLK_PER_BIT) @(posedge clk);
    #1;
    check("break_busy", {31'd0, busy}, 32'd0);
    idle_bits(2);
    check("break_one_word", 32'(vcycles - v0), 32'd1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_bits(1);

    // Overrun
    rdy_fixed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_bits(1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_bits(1);
    check("overrun_valid", {31'd0, rx_valid}, 32'd1);
    check("overrun_data_held", {24'd0, rx_data}, 32'h11);
    check("overrun_flag", {31'd0, overrun}, 32'd1);
    rdy_fixed = 1'b1;
    @(posedge clk);
    #2;
    rdy_fixed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("overrun_valid_cleared", {31'd0, rx_valid}, 32'd0);
    check("overrun_cleared", {31'd0, overrun}, 32'd0);
    check("overrun_drained", 32'(q.size()), 32'd0);
    rdy_fixed = 1'b1;

    // Reset during DATA bit 3
    d = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx = d[3];
    repeat (CLK_PER_BIT / 2) @(posedge clk);
    #1;
    check("midframe_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_parity_err", {31'd0, parity_err}, 32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_bits(1);

    // Randomized frames with random ready back-pressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      d     = 8'($urandom);
      pen   = 1'($urandom);
      podd  = 1'($urandom);
      pflip = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 5) != 0);
      send_frame(d, pen, podd, pflip, stop, 1'b1);
      idle_bits($urandom_range(1, 2));
    end
    rdy_rand = 1'b0;
    rdy_fixed = 1'b1;
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
